game_ctrl_sm: RTL and testbench
===============================

# game_ctrl_sm

Parametrised top-level game-flow controller for the space-invaders design. It sits above the player and enemy-formation blocks and tracks lives, score, wave number and remaining enemies. It gates player and enemy motion, steps through attract, play, respawn, wave-clear and game-over phases, and presents the final score through a valid/ready handshake. It generalises the original single-player wrapper: lives, enemy count, wave count, timers and score scaling are parameters, and it adds respawn delays, bonus lives and a handshake exit path that the original lacks.

## Interface
- lives_p, 3: lives granted at game start
- max_lives_p, 5: cap on lives from bonus awards; must be ≥ lives_p
- num_enemies_p, 55: enemies per wave
- waves_p, 4: distinct waves; wave index wraps to 0 after waves_p-1; ≥2
- score_width_p, 16: score register width
- points_p, 10: points per enemy hit
- respawn_frames_p, 60: frames spent in RESPAWN; ≥1
- clear_frames_p, 90: frames spent in WAVE_CLEAR; ≥1
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- frame_i  in  1  one-cycle pulse per video frame
- start_i  in  1  start button, level
- player_was_hit_i  in  1  one-cycle pulse, player hit
- enemy_was_hit_i  in  1  one-cycle pulse, one enemy destroyed
- enemies_landed_i  in  1  formation reached player row
- state_o  out  3  ATTRACT=0, PLAY=1, RESPAWN=2, WAVE_CLEAR=3, GAME_OVER=4
- lives_o  out  $clog2(max_lives_p+1)  remaining lives
- score_o  out  score_width_p  current/final score
- wave_o  out  $clog2(waves_p)  current wave index
- enemies_left_o  out  $clog2(num_enemies_p+1)  enemies alive this wave
- player_en_o  out  1  high only in PLAY
- enemy_en_o  out  1  high only in PLAY
- wave_reset_o  out  1  one-cycle pulse: reload enemy formation
- valid_o  out  1  final score valid (GAME_OVER)
- ready_i  in  1  consumer accepts final score

## Operation
- Reset (async, immediate): state ATTRACT; score, lives, wave, enemies_left, timer = 0; wave_reset_o = 0; valid_o = 0; enables = 0.
- ATTRACT: on start_i, load lives=lives_p, score=0, wave=0, enemies_left=num_enemies_p, pulse wave_reset_o, go to PLAY. score_o holds the last game's score until start.
- PLAY: priority is enemies_landed_i > player_was_hit_i > enemy_was_hit_i (the enemy hit is still scored when simultaneous).
  - landed: lives=0, go to GAME_OVER.
  - player hit: lives-1. If the result is 0, go to GAME_OVER; else go to RESPAWN with timer=respawn_frames_p.
  - enemy hit: score += points_p, saturating at 2^score_width_p-1. enemies_left-1. If the result is 0 and no player hit occurs that cycle, go to WAVE_CLEAR with timer=clear_frames_p.
  - Player hit plus last-enemy hit in the same cycle: score and decrement both apply; the player-hit path wins. On leaving RESPAWN with enemies_left=0, go to WAVE_CLEAR instead of PLAY.
- RESPAWN: enables low; all hit inputs ignored. Each frame_i decrements timer. On the frame_i where timer==1, go to PLAY (or WAVE_CLEAR if enemies_left==0, timer=clear_frames_p).
- WAVE_CLEAR: enables low; hits ignored. Each frame_i decrements timer. On the frame_i where timer==1:
  - wave = (wave==waves_p-1) ? 0 : wave+1
  - lives = min(lives+1, max_lives_p)
  - enemies_left = num_enemies_p
  - pulse wave_reset_o, go to PLAY.
- GAME_OVER: valid_o=1; score_o stable. valid_o holds until ready_i; valid_o must not drop without a handshake. On valid_o & ready_i, go to ATTRACT; score retained. start_i is ignored here.
- enemy_was_hit_i while enemies_left==0 is ignored; no underflow.

## Timing
- All outputs are registered. Every effect is visible the cycle after the sampled input edge.
- wave_reset_o is high exactly one cycle, coincident with the first PLAY cycle.
- Timer counts frame_i pulses, not clocks. A state dwell is exactly N frame_i pulses after entry; a frame_i on the entry cycle itself is not counted.
- Handshake: transfer on the rising edge where valid_o & ready_i. valid_o is 0 the next cycle. ready_i may be held high beforehand; GAME_OVER then lasts exactly 1 cycle.
- Reset asserted mid-game: immediate return to reset values, with no wave_reset_o pulse.

## Test plan
- Bench override num_enemies_p=4, waves_p=2, respawn_frames_p=2, clear_frames_p=2.
- Start, then 4 enemy hits -> score=40, enemies_left=0, WAVE_CLEAR; after 2 frames -> PLAY, wave=1, lives=4, wave_reset_o one-cycle pulse. Repeat the wave -> wave wraps to 0, lives=5. A third clear -> lives stays 5.
- 3 player hits, each followed by 2-frame respawns -> lives 2,1, then 0 -> GAME_OVER. valid_o=1, score held. Hold ready_i=0 for 10 cycles -> valid_o stays 1. ready_i=1 -> ATTRACT next cycle.
- Same-cycle player hit and last-enemy hit -> score+10, enemies_left=0, RESPAWN; after 2 frames -> WAVE_CLEAR, not PLAY.
- enemies_landed_i with lives=3 together with enemy_was_hit_i -> GAME_OVER, lives=0, score+10.
- score_width_p=6: 7 enemy hits -> score saturates at 63. Reset asserted in RESPAWN -> all outputs 0 asynchronously, state ATTRACT.

Source files
------------

// File: rtl/game_ctrl_sm_if.sv
// game_ctrl_sm_if: control/status bundle between the game-flow controller and the play field.
interface game_ctrl_sm_if #(
    parameter int max_lives_p   = 5,
    parameter int num_enemies_p = 55,
    parameter int waves_p       = 4,
    parameter int score_width_p = 16
);
    logic                               frame, start, player_was_hit, enemy_was_hit, enemies_landed, ready;
    logic [2:0]                         state;
    logic [$clog2(max_lives_p+1)-1:0]   lives;
    logic [score_width_p-1:0]           score;
    logic [$clog2(waves_p)-1:0]         wave;
    logic [$clog2(num_enemies_p+1)-1:0] enemies_left;
    logic                               player_en, enemy_en, wave_reset, valid;
    modport master (
        input  frame, start, player_was_hit, enemy_was_hit, enemies_landed, ready,
        output state, lives, score, wave, enemies_left, player_en, enemy_en, wave_reset, valid
    );
    modport slave (
        output frame, start, player_was_hit, enemy_was_hit, enemies_landed, ready,
        input  state, lives, score, wave, enemies_left, player_en, enemy_en, wave_reset, valid
    );
endinterface

// File: rtl/game_ctrl_sm.sv
// game_ctrl_sm: game-flow controller tracking lives, score, wave and enemies; final score leaves via valid/ready.
module game_ctrl_sm #(
    parameter int lives_p          = 3,
    parameter int max_lives_p      = 5,
    parameter int num_enemies_p    = 55,
    parameter int waves_p          = 4,
    parameter int score_width_p    = 16,
    parameter int points_p         = 10,
    parameter int respawn_frames_p = 60,
    parameter int clear_frames_p   = 90
) (
    input logic clk,
    input logic rst,
    game_ctrl_sm_if.master bus
);
    localparam int lw = $clog2(max_lives_p + 1);
    localparam int ew = $clog2(num_enemies_p + 1);
    localparam int ww = $clog2(waves_p);
    localparam int tw = $clog2((respawn_frames_p > clear_frames_p ? respawn_frames_p : clear_frames_p) + 1);
    localparam logic [2:0] st_attract = 3'd0;
    localparam logic [2:0] st_play    = 3'd1;
    localparam logic [2:0] st_respawn = 3'd2;
    localparam logic [2:0] st_clear   = 3'd3;
    localparam logic [2:0] st_over    = 3'd4;
    logic [2:0]               state;
    logic [lw-1:0]            lives;
    logic [score_width_p-1:0] score;
    logic [ww-1:0]            wave;
    logic [ew-1:0]            enemies_left;
    logic [tw-1:0]            timer;
    logic                     wave_reset;
    logic [score_width_p:0]   sum;
    logic                     hit_ok;
    assign sum    = {1'b0, score} + (score_width_p + 1)'(points_p);
    assign hit_ok = bus.enemy_was_hit && enemies_left != '0;
    assign bus.state        = state;
    assign bus.lives        = lives;
    assign bus.score        = score;
    assign bus.wave         = wave;
    assign bus.enemies_left = enemies_left;
    assign bus.wave_reset   = wave_reset;
    assign bus.player_en    = state == st_play;
    assign bus.enemy_en     = state == st_play;
    assign bus.valid        = state == st_over;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state        <= st_attract;
            lives        <= '0;
            score        <= '0;
            wave         <= '0;
            enemies_left <= '0;
            timer        <= '0;
            wave_reset   <= 1'b0;
        end else begin
            wave_reset <= 1'b0;
            case (state)
                st_attract: if (bus.start) begin
                    lives        <= lw'(lives_p);
                    score        <= '0;
                    wave         <= '0;
                    enemies_left <= ew'(num_enemies_p);
                    wave_reset   <= 1'b1;
                    state        <= st_play;
                end
                st_play: begin
                    // enemy hit is scored even when a higher-priority event wins the transition
                    if (hit_ok) begin
                        score        <= sum[score_width_p] ? '1 : sum[score_width_p-1:0];
                        enemies_left <= enemies_left - ew'(1);
                    end
                    if (bus.enemies_landed) begin
                        lives <= '0;
                        state <= st_over;
                    end else if (bus.player_was_hit) begin
                        lives <= lives - lw'(1);
                        timer <= tw'(respawn_frames_p);
                        state <= lives == lw'(1) ? st_over : st_respawn;
                    end else if (hit_ok && enemies_left == ew'(1)) begin
                        timer <= tw'(clear_frames_p);
                        state <= st_clear;
                    end
                end
                st_respawn: if (bus.frame) begin
                    timer <= timer - tw'(1);
                    if (timer == tw'(1)) begin
                        timer <= tw'(clear_frames_p);
                        state <= enemies_left == '0 ? st_clear : st_play;
                    end
                end
                st_clear: if (bus.frame) begin
                    timer <= timer - tw'(1);
                    if (timer == tw'(1)) begin
                        wave         <= wave == ww'(waves_p - 1) ? '0 : wave + ww'(1);
                        lives        <= lives == lw'(max_lives_p) ? lives : lives + lw'(1);
                        enemies_left <= ew'(num_enemies_p);
                        wave_reset   <= 1'b1;
                        state        <= st_play;
                    end
                end
                st_over: if (bus.ready) state <= st_attract;
                default: state <= st_attract;
            endcase
        end
endmodule

// File: tb/tb_game_ctrl_sm.sv
// tb_game_ctrl_sm: directed scenarios for game_ctrl_sm with hand-computed expectations.
module tb_game_ctrl_sm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    game_ctrl_sm_if #(.num_enemies_p(4), .waves_p(2)) b();
    game_ctrl_sm_if #(.num_enemies_p(4), .waves_p(2), .score_width_p(6)) s();
    game_ctrl_sm #(.num_enemies_p(4), .waves_p(2), .respawn_frames_p(2), .clear_frames_p(2))
        dut (.clk(clk), .rst(rst), .bus(b.master));
    game_ctrl_sm #(.num_enemies_p(4), .waves_p(2), .respawn_frames_p(2), .clear_frames_p(2), .score_width_p(6))
        dut_s (.clk(clk), .rst(rst), .bus(s.master));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic start_game;
        b.start = 1'b1; tick(); b.start = 1'b0;
    endtask
    task automatic enemy;
        b.enemy_was_hit = 1'b1; tick(); b.enemy_was_hit = 1'b0;
    endtask
    task automatic player;
        b.player_was_hit = 1'b1; tick(); b.player_was_hit = 1'b0;
    endtask
    task automatic frame;
        b.frame = 1'b1; tick(); b.frame = 1'b0;
    endtask
    task automatic s_enemy;
        s.enemy_was_hit = 1'b1; tick(); s.enemy_was_hit = 1'b0;
    endtask

    task automatic test_reset;
        tests++; if (b.state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", b.state); end
        tests++; if (b.lives !== 3'd0) begin fails++; $display("FAIL reset_lives: got %0d want 0", b.lives); end
        tests++; if (b.score !== 16'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", b.score); end
        tests++; if (b.wave !== 1'b0) begin fails++; $display("FAIL reset_wave: got %0d want 0", b.wave); end
        tests++; if (b.enemies_left !== 3'd0) begin fails++; $display("FAIL reset_enemies: got %0d want 0", b.enemies_left); end
        tests++; if ({b.valid, b.wave_reset, b.player_en, b.enemy_en} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {b.valid, b.wave_reset, b.player_en, b.enemy_en}); end
    endtask

    task automatic test_start;
        start_game();
        tests++; if (b.state !== 3'd1) begin fails++; $display("FAIL start_state: got %0d want 1", b.state); end
        tests++; if (b.lives !== 3'd3) begin fails++; $display("FAIL start_lives: got %0d want 3", b.lives); end
        tests++; if (b.enemies_left !== 3'd4) begin fails++; $display("FAIL start_enemies: got %0d want 4", b.enemies_left); end
        tests++; if (b.wave_reset !== 1'b1) begin fails++; $display("FAIL start_wave_reset: got %0d want 1", b.wave_reset); end
        tests++; if ({b.player_en, b.enemy_en} !== 2'b11) begin fails++; $display("FAIL start_enables: got %b want 11", {b.player_en, b.enemy_en}); end
        tick();
        tests++; if (b.wave_reset !== 1'b0) begin fails++; $display("FAIL start_wave_reset_drop: got %0d want 0", b.wave_reset); end
    endtask

    task automatic test_wave_clear(input int exp_wave, input int exp_lives, input int exp_score);
        for (int i = 0; i < 4; i++) begin
            enemy();
            tests++; if (b.enemies_left !== 3'(3 - i)) begin fails++; $display("FAIL clear_enemies: got %0d want %0d", b.enemies_left, 3 - i); end
        end
        tests++; if (b.state !== 3'd3) begin fails++; $display("FAIL clear_state: got %0d want 3", b.state); end
        tests++; if (b.score !== 16'(exp_score)) begin fails++; $display("FAIL clear_score: got %0d want %0d", b.score, exp_score); end
        tests++; if (b.player_en !== 1'b0) begin fails++; $display("FAIL clear_enable: got %0d want 0", b.player_en); end
        frame();
        tests++; if (b.state !== 3'd3) begin fails++; $display("FAIL clear_dwell: got %0d want 3", b.state); end
        frame();
        tests++; if (b.state !== 3'd1) begin fails++; $display("FAIL clear_exit: got %0d want 1", b.state); end
        tests++; if (b.wave !== 1'(exp_wave)) begin fails++; $display("FAIL clear_wave: got %0d want %0d", b.wave, exp_wave); end
        tests++; if (b.lives !== 3'(exp_lives)) begin fails++; $display("FAIL clear_lives: got %0d want %0d", b.lives, exp_lives); end
        tests++; if (b.enemies_left !== 3'd4) begin fails++; $display("FAIL clear_reload: got %0d want 4", b.enemies_left); end
        tests++; if (b.wave_reset !== 1'b1) begin fails++; $display("FAIL clear_wave_reset: got %0d want 1", b.wave_reset); end
        tick();
        tests++; if (b.wave_reset !== 1'b0) begin fails++; $display("FAIL clear_wave_reset_drop: got %0d want 0", b.wave_reset); end
    endtask

    task automatic test_game_over;
        for (int i = 1; i <= 5; i++) begin
            player();
            tests++; if (b.lives !== 3'(5 - i)) begin fails++; $display("FAIL over_lives: got %0d want %0d", b.lives, 5 - i); end
            if (i < 5) begin
                tests++; if (b.state !== 3'd2) begin fails++; $display("FAIL over_respawn: got %0d want 2", b.state); end
                frame();
                frame();
                tests++; if (b.state !== 3'd1) begin fails++; $display("FAIL over_back_to_play: got %0d want 1", b.state); end
            end
        end
        tests++; if (b.state !== 3'd4) begin fails++; $display("FAIL over_state: got %0d want 4", b.state); end
        tests++; if (b.score !== 16'd120) begin fails++; $display("FAIL over_score: got %0d want 120", b.score); end
        b.ready = 1'b0;
        b.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++; if (b.valid !== 1'b1) begin fails++; $display("FAIL over_valid_hold: got %0d want 1", b.valid); end
        end
        b.start = 1'b0;
        tests++; if (b.state !== 3'd4) begin fails++; $display("FAIL over_start_ignored: got %0d want 4", b.state); end
        b.ready = 1'b1; tick(); b.ready = 1'b0;
        tests++; if (b.state !== 3'd0) begin fails++; $display("FAIL over_handshake: got %0d want 0", b.state); end
        tests++; if (b.valid !== 1'b0) begin fails++; $display("FAIL over_valid_drop: got %0d want 0", b.valid); end
        tick();
        tests++; if (b.score !== 16'd120) begin fails++; $display("FAIL over_score_retained: got %0d want 120", b.score); end
    endtask

    task automatic test_simultaneous;
        start_game();
        tests++; if (b.score !== 16'd0) begin fails++; $display("FAIL simul_score_clear: got %0d want 0", b.score); end
        tests++; if (b.wave !== 1'b0) begin fails++; $display("FAIL simul_wave_clear: got %0d want 0", b.wave); end
        enemy(); enemy(); enemy();
        b.player_was_hit = 1'b1; b.enemy_was_hit = 1'b1; tick(); b.player_was_hit = 1'b0; b.enemy_was_hit = 1'b0;
        tests++; if (b.state !== 3'd2) begin fails++; $display("FAIL simul_state: got %0d want 2", b.state); end
        tests++; if (b.score !== 16'd40) begin fails++; $display("FAIL simul_score: got %0d want 40", b.score); end
        tests++; if (b.enemies_left !== 3'd0) begin fails++; $display("FAIL simul_enemies: got %0d want 0", b.enemies_left); end
        tests++; if (b.lives !== 3'd2) begin fails++; $display("FAIL simul_lives: got %0d want 2", b.lives); end
        enemy();
        tests++; if (b.score !== 16'd40) begin fails++; $display("FAIL simul_respawn_ignores_hit: got %0d want 40", b.score); end
        frame(); frame();
        tests++; if (b.state !== 3'd3) begin fails++; $display("FAIL simul_to_clear: got %0d want 3", b.state); end
        frame(); frame();
        tests++; if (b.state !== 3'd1) begin fails++; $display("FAIL simul_play: got %0d want 1", b.state); end
        tests++; if (b.wave !== 1'b1) begin fails++; $display("FAIL simul_wave: got %0d want 1", b.wave); end
        tests++; if (b.lives !== 3'd3) begin fails++; $display("FAIL simul_bonus: got %0d want 3", b.lives); end
        tests++; if (b.wave_reset !== 1'b1) begin fails++; $display("FAIL simul_wave_reset: got %0d want 1", b.wave_reset); end
    endtask

    task automatic test_landed;
        b.enemies_landed = 1'b1; b.enemy_was_hit = 1'b1; b.ready = 1'b1;
        tick();
        b.enemies_landed = 1'b0; b.enemy_was_hit = 1'b0;
        tests++; if (b.state !== 3'd4) begin fails++; $display("FAIL landed_state: got %0d want 4", b.state); end
        tests++; if (b.lives !== 3'd0) begin fails++; $display("FAIL landed_lives: got %0d want 0", b.lives); end
        tests++; if (b.score !== 16'd50) begin fails++; $display("FAIL landed_score: got %0d want 50", b.score); end
        tests++; if (b.valid !== 1'b1) begin fails++; $display("FAIL landed_valid: got %0d want 1", b.valid); end
        tick();
        b.ready = 1'b0;
        tests++; if (b.state !== 3'd0) begin fails++; $display("FAIL landed_one_cycle_over: got %0d want 0", b.state); end
    endtask

    task automatic test_saturation;
        s.start = 1'b1; tick(); s.start = 1'b0;
        for (int i = 0; i < 4; i++) s_enemy();
        s.frame = 1'b1; tick(); tick(); s.frame = 1'b0;
        tests++; if (s.state !== 3'd1 || s.score !== 6'd40) begin fails++; $display("FAIL sat_wave1: got state %0d score %0d want 1 40", s.state, s.score); end
        s_enemy();
        tests++; if (s.score !== 6'd50) begin fails++; $display("FAIL sat_50: got %0d want 50", s.score); end
        s_enemy();
        tests++; if (s.score !== 6'd60) begin fails++; $display("FAIL sat_60: got %0d want 60", s.score); end
        s_enemy();
        tests++; if (s.score !== 6'd63) begin fails++; $display("FAIL sat_63: got %0d want 63", s.score); end
        s_enemy();
        tests++; if (s.score !== 6'd63) begin fails++; $display("FAIL sat_hold: got %0d want 63", s.score); end
        tests++; if (s.state !== 3'd3) begin fails++; $display("FAIL sat_clear: got %0d want 3", s.state); end
    endtask

    task automatic test_reset_mid;
        start_game();
        enemy();
        player();
        tests++; if (b.state !== 3'd2 || b.score !== 16'd10 || b.lives !== 3'd2) begin fails++; $display("FAIL mid_setup: got state %0d score %0d lives %0d want 2 10 2", b.state, b.score, b.lives); end
        #2 rst = 1'b1;
        #1;
        tests++; if (b.state !== 3'd0) begin fails++; $display("FAIL mid_state: got %0d want 0", b.state); end
        tests++; if (b.score !== 16'd0) begin fails++; $display("FAIL mid_score: got %0d want 0", b.score); end
        tests++; if (b.lives !== 3'd0) begin fails++; $display("FAIL mid_lives: got %0d want 0", b.lives); end
        tests++; if (b.enemies_left !== 3'd0) begin fails++; $display("FAIL mid_enemies: got %0d want 0", b.enemies_left); end
        tests++; if ({b.valid, b.wave_reset, b.player_en, b.enemy_en} !== 4'b0) begin fails++; $display("FAIL mid_flags: got %b want 0000", {b.valid, b.wave_reset, b.player_en, b.enemy_en}); end
        tests++; if (s.score !== 6'd0 || s.state !== 3'd0) begin fails++; $display("FAIL mid_second: got state %0d score %0d want 0 0", s.state, s.score); end
        tick();
        tests++; if (b.wave_reset !== 1'b0) begin fails++; $display("FAIL mid_no_pulse: got %0d want 0", b.wave_reset); end
    endtask

    initial begin
        {b.frame, b.start, b.player_was_hit, b.enemy_was_hit, b.enemies_landed, b.ready} = '0;
        {s.frame, s.start, s.player_was_hit, s.enemy_was_hit, s.enemies_landed, s.ready} = '0;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_start();
        test_wave_clear(1, 4, 40);
        test_wave_clear(0, 5, 80);
        test_wave_clear(1, 5, 120);
        test_game_over();
        test_simultaneous();
        test_landed();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
